// File: rtl/util_dac_timestamp_gen.sv
// DAC sample timestamp generator: loads immediately or on a synchronised trigger
// edge, advances per dac_valid strobe, and counts sample underflows while running.
module util_dac_timestamp_gen #(
  parameter int SAMPLES_PER_VALID   = 1,
  parameter int TRIGGER_SYNC_STAGES = 2
) (
  input  logic        dac_clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        dac_valid,
  input  logic        data_valid,
  input  logic [63:0] load_value,
  input  logic        load_now,
  input  logic        load_arm,
  input  logic        trigger,
  input  logic        underflow_clear,
  output logic [63:0] timestamp,
  output logic        timestamp_valid,
  output logic [1:0]  state,
  output logic [31:0] underflow_count,
  output logic        underflow_flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  localparam logic [63:0] TS_INC = 64'(SAMPLES_PER_VALID);
  localparam logic [31:0] UF_MAX = 32'hFFFF_FFFF;

  state_t                         state_r;
  state_t                         state_next_s;
  logic [63:0]                    ts_r;
  logic [63:0]                    ts_next_s;
  logic                           ts_valid_r;
  logic [TRIGGER_SYNC_STAGES-1:0] sync_r;
  logic                           trig_last_r;
  logic                           trig_edge_r;
  logic                           uf_event_s;
  logic [31:0]                    uf_count_r;
  logic                           uf_flag_r;

  // Trigger synchroniser; the edge pulse is registered so the load lands one cycle later.
  always_ff @(posedge dac_clk or negedge resetn) begin
    if (!resetn) begin
      sync_r      <= '0;
      trig_last_r <= 1'b0;
      trig_edge_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[TRIGGER_SYNC_STAGES-2:0], trigger};
      trig_last_r <= sync_r[TRIGGER_SYNC_STAGES-1];
      trig_edge_r <= sync_r[TRIGGER_SYNC_STAGES-1] & ~trig_last_r;
    end
  end

  // Next-state and next-timestamp; loads always win over increments.
  always_comb begin
    state_next_s = state_r;
    ts_next_s    = ts_r;
    if (!enable) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_now) begin
            ts_next_s    = load_value;
            state_next_s = ST_RUNNING;
          end else if (load_arm) begin
            state_next_s = ST_ARMED;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (load_now || trig_edge_r) begin
            ts_next_s    = load_value;
            state_next_s = ST_RUNNING;
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_RUNNING: begin
          if (load_now) begin
            ts_next_s = load_value;
          end else if (load_arm) begin
            state_next_s = ST_ARMED;
          end else if (dac_valid) begin
            ts_next_s = ts_r + TS_INC;
          end else begin
            ts_next_s = ts_r;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, timestamp and valid registers.
  always_ff @(posedge dac_clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      ts_r       <= 64'd0;
      ts_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ts_r       <= ts_next_s;
      ts_valid_r <= (state_next_s == ST_RUNNING);
    end
  end

  assign uf_event_s = (state_r == ST_RUNNING) && dac_valid && !data_valid;

  // Saturating underflow counter; a coincident event survives a clear.
  always_ff @(posedge dac_clk or negedge resetn) begin
    if (!resetn) begin
      uf_count_r <= 32'd0;
      uf_flag_r  <= 1'b0;
    end else if (underflow_clear) begin
      uf_count_r <= uf_event_s ? 32'd1 : 32'd0;
      uf_flag_r  <= uf_event_s;
    end else if (uf_event_s) begin
      uf_count_r <= (uf_count_r == UF_MAX) ? uf_count_r : uf_count_r + 32'd1;
      uf_flag_r  <= 1'b1;
    end else begin
      uf_count_r <= uf_count_r;
      uf_flag_r  <= uf_flag_r;
    end
  end

  assign timestamp       = ts_r;
  assign timestamp_valid = ts_valid_r;
  assign state           = state_r;
  assign underflow_count = uf_count_r;
  assign underflow_flag  = uf_flag_r;

endmodule

// File: tb/tb_util_dac_timestamp_gen.sv
// Directed self-checking bench; a second instance with SAMPLES_PER_VALID=4 shares all inputs.
module tb_util_dac_timestamp_gen;

  logic        dac_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        dac_valid = 1'b0;
  logic        data_valid = 1'b1;
  logic [63:0] load_value = 64'd0;
  logic        load_now = 1'b0;
  logic        load_arm = 1'b0;
  logic        trigger = 1'b0;
  logic        underflow_clear = 1'b0;

  logic [63:0] timestamp, timestamp4;
  logic        timestamp_valid, timestamp_valid4;
  logic [1:0]  state, state4;
  logic [31:0] underflow_count, underflow_count4;
  logic        underflow_flag, underflow_flag4;

  int n_checks = 0;
  int n_pass = 0;

  always #5 dac_clk = ~dac_clk;

  util_dac_timestamp_gen #(.SAMPLES_PER_VALID(1), .TRIGGER_SYNC_STAGES(2)) dut (
    .dac_clk(dac_clk), .resetn(resetn), .enable(enable), .dac_valid(dac_valid),
    .data_valid(data_valid), .load_value(load_value), .load_now(load_now),
    .load_arm(load_arm), .trigger(trigger), .underflow_clear(underflow_clear),
    .timestamp(timestamp), .timestamp_valid(timestamp_valid), .state(state),
    .underflow_count(underflow_count), .underflow_flag(underflow_flag)
  );

  util_dac_timestamp_gen #(.SAMPLES_PER_VALID(4), .TRIGGER_SYNC_STAGES(2)) dut4 (
    .dac_clk(dac_clk), .resetn(resetn), .enable(enable), .dac_valid(dac_valid),
    .data_valid(data_valid), .load_value(load_value), .load_now(load_now),
    .load_arm(load_arm), .trigger(trigger), .underflow_clear(underflow_clear),
    .timestamp(timestamp4), .timestamp_valid(timestamp_valid4), .state(state4),
    .underflow_count(underflow_count4), .underflow_flag(underflow_flag4)
  );

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (timestamp !== 64'd0) $display("FAIL reset_ts: got %h expected %h", timestamp, 64'd0); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected %0d", state, 2'd0); else n_pass++;
    n_checks++; if (timestamp_valid !== 1'b0) $display("FAIL reset_tvalid: got %b expected %b", timestamp_valid, 1'b0); else n_pass++;
    n_checks++; if (underflow_count !== 32'd0) $display("FAIL reset_ufcount: got %0d expected %0d", underflow_count, 32'd0); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b0) $display("FAIL reset_ufflag: got %b expected %b", underflow_flag, 1'b0); else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_load_now();
    enable = 1'b1;
    load_value = 64'h1000;
    load_now = 1'b1;
    tick();
    load_now = 1'b0;
    n_checks++; if (timestamp !== 64'h1000) $display("FAIL load_now_ts: got %h expected %h", timestamp, 64'h1000); else n_pass++;
    n_checks++; if (state !== 2'd2) $display("FAIL load_now_state: got %0d expected %0d", state, 2'd2); else n_pass++;
    n_checks++; if (timestamp_valid !== 1'b1) $display("FAIL load_now_tvalid: got %b expected %b", timestamp_valid, 1'b1); else n_pass++;
    dac_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dac_valid = 1'b0;
    n_checks++; if (timestamp !== 64'h1005) $display("FAIL strobes_ts: got %h expected %h", timestamp, 64'h1005); else n_pass++;
    n_checks++; if (underflow_count !== 32'd0) $display("FAIL strobes_nouf: got %0d expected %0d", underflow_count, 32'd0); else n_pass++;
  endtask

  task automatic test_load_priority();
    load_value = 64'h50;
    load_now = 1'b1;
    dac_valid = 1'b1;
    tick();
    load_now = 1'b0;
    dac_valid = 1'b0;
    n_checks++; if (timestamp !== 64'h50) $display("FAIL load_prio_ts: got %h expected %h", timestamp, 64'h50); else n_pass++;
  endtask

  task automatic test_underflow();
    dac_valid = 1'b1;
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (underflow_count !== 32'd3) $display("FAIL uf_count3: got %0d expected %0d", underflow_count, 32'd3); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b1) $display("FAIL uf_flag: got %b expected %b", underflow_flag, 1'b1); else n_pass++;
    underflow_clear = 1'b1;
    tick();
    n_checks++; if (underflow_count !== 32'd1) $display("FAIL uf_clear_coincident_count: got %0d expected %0d", underflow_count, 32'd1); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b1) $display("FAIL uf_clear_coincident_flag: got %b expected %b", underflow_flag, 1'b1); else n_pass++;
    dac_valid = 1'b0;
    data_valid = 1'b1;
    tick();
    underflow_clear = 1'b0;
    n_checks++; if (underflow_count !== 32'd0) $display("FAIL uf_clear_count: got %0d expected %0d", underflow_count, 32'd0); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b0) $display("FAIL uf_clear_flag: got %b expected %b", underflow_flag, 1'b0); else n_pass++;
  endtask

  task automatic test_trigger();
    load_value = 64'h200;
    load_now = 1'b1;
    tick();
    load_now = 1'b0;
    load_arm = 1'b1;
    dac_valid = 1'b1;
    tick();
    load_arm = 1'b0;
    n_checks++; if (state !== 2'd1) $display("FAIL arm_state: got %0d expected %0d", state, 2'd1); else n_pass++;
    n_checks++; if (timestamp !== 64'h200) $display("FAIL arm_no_inc: got %h expected %h", timestamp, 64'h200); else n_pass++;
    n_checks++; if (timestamp_valid !== 1'b0) $display("FAIL arm_tvalid: got %b expected %b", timestamp_valid, 1'b0); else n_pass++;
    load_value = 64'hABCD;
    trigger = 1'b1;
    tick();
    tick();
    n_checks++; if (state !== 2'd1) $display("FAIL trig_wait_state: got %0d expected %0d", state, 2'd1); else n_pass++;
    tick();
    n_checks++; if (timestamp !== 64'h200) $display("FAIL trig_not_early: got %h expected %h", timestamp, 64'h200); else n_pass++;
    tick();
    dac_valid = 1'b0;
    n_checks++; if (timestamp !== 64'hABCD) $display("FAIL trig_load_ts: got %h expected %h", timestamp, 64'hABCD); else n_pass++;
    n_checks++; if (state !== 2'd2) $display("FAIL trig_load_state: got %0d expected %0d", state, 2'd2); else n_pass++;
    load_arm = 1'b1;
    load_value = 64'h9999;
    tick();
    load_arm = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (state !== 2'd1) $display("FAIL held_trig_state: got %0d expected %0d", state, 2'd1); else n_pass++;
    n_checks++; if (timestamp !== 64'hABCD) $display("FAIL held_trig_ts: got %h expected %h", timestamp, 64'hABCD); else n_pass++;
    trigger = 1'b0;
  endtask

  task automatic test_wrap();
    load_value = 64'hFFFF_FFFF_FFFF_FFFE;
    load_now = 1'b1;
    tick();
    load_now = 1'b0;
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    n_checks++; if (timestamp4 !== 64'h2) $display("FAIL wrap_spv4: got %h expected %h", timestamp4, 64'h2); else n_pass++;
    n_checks++; if (timestamp !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_spv1_max: got %h expected %h", timestamp, 64'hFFFF_FFFF_FFFF_FFFF); else n_pass++;
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    n_checks++; if (timestamp !== 64'h0) $display("FAIL wrap_spv1_zero: got %h expected %h", timestamp, 64'h0); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b0) $display("FAIL wrap_no_flag: got %b expected %b", underflow_flag, 1'b0); else n_pass++;
  endtask

  task automatic test_enable();
    load_value = 64'h300;
    load_now = 1'b1;
    tick();
    load_now = 1'b0;
    enable = 1'b0;
    dac_valid = 1'b1;
    tick();
    n_checks++; if (state !== 2'd0) $display("FAIL disable_state: got %0d expected %0d", state, 2'd0); else n_pass++;
    n_checks++; if (timestamp_valid !== 1'b0) $display("FAIL disable_tvalid: got %b expected %b", timestamp_valid, 1'b0); else n_pass++;
    n_checks++; if (timestamp !== 64'h300) $display("FAIL disable_hold: got %h expected %h", timestamp, 64'h300); else n_pass++;
    dac_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b1;
    load_value = 64'h70;
    load_now = 1'b1;
    tick();
    load_now = 1'b0;
    dac_valid = 1'b1;
    data_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    dac_valid = 1'b0;
    data_valid = 1'b1;
    n_checks++; if (timestamp !== 64'h77) $display("FAIL prereset_ts: got %h expected %h", timestamp, 64'h77); else n_pass++;
    n_checks++; if (underflow_count !== 32'd7) $display("FAIL prereset_uf: got %0d expected %0d", underflow_count, 32'd7); else n_pass++;
    trigger = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (timestamp !== 64'd0) $display("FAIL async_rst_ts: got %h expected %h", timestamp, 64'd0); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL async_rst_state: got %0d expected %0d", state, 2'd0); else n_pass++;
    n_checks++; if (timestamp_valid !== 1'b0) $display("FAIL async_rst_tvalid: got %b expected %b", timestamp_valid, 1'b0); else n_pass++;
    n_checks++; if (underflow_count !== 32'd0) $display("FAIL async_rst_uf: got %0d expected %0d", underflow_count, 32'd0); else n_pass++;
    n_checks++; if (underflow_flag !== 1'b0) $display("FAIL async_rst_flag: got %b expected %b", underflow_flag, 1'b0); else n_pass++;
    tick();
    tick();
    resetn = 1'b1;
    load_value = 64'h1234;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (state !== 2'd0) $display("FAIL release_state: got %0d expected %0d", state, 2'd0); else n_pass++;
    n_checks++; if (timestamp !== 64'd0) $display("FAIL release_ts: got %h expected %h", timestamp, 64'd0); else n_pass++;
    dac_valid = 1'b1;
    data_valid = 1'b0;
    tick();
    tick();
    dac_valid = 1'b0;
    data_valid = 1'b1;
    n_checks++; if (underflow_count !== 32'd0) $display("FAIL idle_no_uf: got %0d expected %0d", underflow_count, 32'd0); else n_pass++;
    trigger = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_now();
    test_load_priority();
    test_underflow();
    test_trigger();
    test_wrap();
    test_enable();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
